// File: rtl/ps2_keymatrix_if.sv
// Byte-stream, map-config and ULA keyboard-port signals of the scancode matrix mapper.
// The slave modport is the mapper; the master modport is its surroundings.
interface ps2_keymatrix_if #(
    parameter int ROWS  = 8,
    parameter int COLS  = 5,
    parameter int CFG_W = 9
);
    logic             in_valid;
    logic [7:0]       in_byte;
    logic             in_err;
    logic             in_ready;
    logic             cfg_we;
    logic [8:0]       cfg_addr;
    logic [CFG_W-1:0] cfg_data;
    logic             cfg_ready;
    logic [ROWS-1:0]  zxkb_addr;
    logic [COLS-1:0]  zxkb_data;
    logic             key_pause;
    logic             overflow;
    logic             any_key;

    modport slave (
        input  in_valid, in_byte, in_err, cfg_we, cfg_addr, cfg_data, zxkb_addr,
        output in_ready, cfg_ready, zxkb_data, key_pause, overflow, any_key
    );

    modport master (
        output in_valid, in_byte, in_err, cfg_we, cfg_addr, cfg_data, zxkb_addr,
        input  in_ready, cfg_ready, zxkb_data, key_pause, overflow, any_key
    );
endinterface

// File: rtl/ps2_keymatrix.sv
// PS/2 scancode to ZX matrix mapper with loadable map and per-key reference counts.
// Key bytes update counters two edges after acceptance (in_ready low meanwhile); matrix read is combinational.
module ps2_keymatrix #(
    parameter int ROWS   = 8,
    parameter int COLS   = 5,
    parameter int CNT_W  = 2,
    parameter int CS_ROW = 0,
    parameter int CS_COL = 0,
    parameter int SS_ROW = 7,
    parameter int SS_COL = 1,
    parameter int ROW_W  = $clog2(ROWS),
    parameter int COL_W  = $clog2(COLS)
) (
    input  logic           clk,
    input  logic           rst,
    ps2_keymatrix_if.slave bus
);
    localparam int NK     = ROWS * COLS;
    localparam int CFG_W  = ROW_W + COL_W + 3;
    localparam int CS_IDX = CS_ROW * COLS + CS_COL;
    localparam int SS_IDX = SS_ROW * COLS + SS_COL;
    localparam logic [CNT_W+1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};

    typedef enum logic [1:0] {ST_FLUSH, ST_IDLE, ST_LOOKUP, ST_UPDATE} state_t;

    state_t           state_q;
    logic [8:0]       flush_idx_q;
    logic [8:0]       addr_q;
    logic             ext_q, brk_q, ovf_q, pause_q, held_rd_q;
    logic [2:0]       skip_q;
    logic [CFG_W-1:0] map_rd_q;
    logic [CNT_W-1:0] cnt_q [NK];
    logic [CNT_W-1:0] cnt_d [NK];
    logic             ovf_d;

    logic [CFG_W-1:0] map_ram [512];
    logic [511:0]     held_ram;

    logic       accept, cfg_wr, flush_req, do_inc, do_dec, held_we;
    logic [8:0] held_waddr;
    logic [1:0] rd_mod;
    int         rd_row_i, rd_col_i, prim_idx;

    assign bus.cfg_ready = (state_q == ST_IDLE);
    assign bus.in_ready  = (state_q == ST_IDLE) && !bus.cfg_we;
    assign bus.key_pause = pause_q;
    assign bus.overflow  = ovf_q;

    assign accept    = bus.in_valid && bus.in_ready;
    assign cfg_wr    = bus.cfg_we && bus.cfg_ready;
    // A skipped byte never triggers the BAT flush; framing errors always do.
    assign flush_req = accept && (bus.in_err ||
                       (skip_q == 3'd0 && bus.in_byte == 8'hAA && !ext_q && !brk_q));

    assign rd_mod     = map_rd_q[CFG_W-2 -: 2];
    assign do_inc     = (state_q == ST_UPDATE) && map_rd_q[CFG_W-1] && !brk_q && !held_rd_q;
    assign do_dec     = (state_q == ST_UPDATE) && map_rd_q[CFG_W-1] && brk_q && held_rd_q;
    assign held_we    = (state_q == ST_FLUSH) || do_inc || do_dec;
    assign held_waddr = (state_q == ST_FLUSH) ? flush_idx_q : addr_q;

    always_ff @(posedge clk) begin
        if (cfg_wr) map_ram[bus.cfg_addr] <= bus.cfg_data;
        if (held_we) held_ram[held_waddr] <= do_inc;
        if (accept) begin
            map_rd_q  <= map_ram[{ext_q, bus.in_byte}];
            held_rd_q <= held_ram[{ext_q, bus.in_byte}];
        end
    end

    always_comb begin
        rd_row_i = int'(map_rd_q[COL_W +: ROW_W]);
        rd_col_i = int'(map_rd_q[COL_W-1:0]);
        prim_idx = (rd_row_i < ROWS && rd_col_i < COLS) ? rd_row_i * COLS + rd_col_i : NK;
    end

    // Primary and modifier steps are summed per counter, so a key mapped onto CS itself gets +2.
    always_comb begin
        logic [1:0]       step;
        logic [CNT_W+1:0] ext_cnt, ext_step, sum, diff;
        ovf_d = 1'b0;
        cnt_d = cnt_q;
        for (int i = 0; i < NK; i++) begin
            step = 2'd0;
            if (i == prim_idx) step = step + 2'd1;
            if (i == CS_IDX && rd_mod == 2'b01) step = step + 2'd1;
            if (i == SS_IDX && rd_mod == 2'b10) step = step + 2'd1;
            ext_cnt  = {2'b00, cnt_q[i]};
            ext_step = {{CNT_W{1'b0}}, step};
            sum      = ext_cnt + ext_step;
            diff     = ext_cnt - ext_step;
            if (do_inc) begin
                if (sum > CNT_MAX) begin
                    cnt_d[i] = CNT_MAX[CNT_W-1:0];
                    ovf_d    = 1'b1;
                end else begin
                    cnt_d[i] = sum[CNT_W-1:0];
                end
            end else if (do_dec) begin
                cnt_d[i] = (ext_cnt >= ext_step) ? diff[CNT_W-1:0] : '0;
            end
        end
    end

    always_comb begin
        logic hit;
        bus.zxkb_data = '1;
        bus.any_key   = 1'b0;
        for (int c = 0; c < COLS; c++) begin
            hit = 1'b0;
            for (int r = 0; r < ROWS; r++)
                if (!bus.zxkb_addr[r] && cnt_q[r*COLS+c] != '0) hit = 1'b1;
            bus.zxkb_data[c] = !hit;
        end
        for (int i = 0; i < NK; i++)
            if (cnt_q[i] != '0) bus.any_key = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FLUSH;
            flush_idx_q <= '0;
            addr_q      <= '0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            skip_q      <= '0;
            ovf_q       <= 1'b0;
            pause_q     <= 1'b0;
            cnt_q       <= '{default: '0};
        end else begin
            pause_q <= 1'b0;
            case (state_q)
                ST_FLUSH: begin
                    cnt_q       <= '{default: '0};
                    flush_idx_q <= flush_idx_q + 9'd1;
                    if (flush_idx_q == 9'h1FF) state_q <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (flush_req) begin
                        state_q     <= ST_FLUSH;
                        flush_idx_q <= '0;
                        ext_q       <= 1'b0;
                        brk_q       <= 1'b0;
                        skip_q      <= '0;
                        ovf_q       <= 1'b0;
                        cnt_q       <= '{default: '0};
                    end else if (accept) begin
                        if (skip_q != 3'd0) begin
                            skip_q <= skip_q - 3'd1;
                        end else if (bus.in_byte == 8'hE0) begin
                            ext_q <= 1'b1;
                        end else if (bus.in_byte == 8'hF0) begin
                            brk_q <= 1'b1;
                        end else if (bus.in_byte == 8'hE1) begin
                            skip_q  <= 3'd7;
                            pause_q <= 1'b1;
                        end else begin
                            addr_q  <= {ext_q, bus.in_byte};
                            state_q <= ST_LOOKUP;
                        end
                    end
                end
                ST_LOOKUP: state_q <= ST_UPDATE;
                ST_UPDATE: begin
                    cnt_q   <= cnt_d;
                    if (ovf_d) ovf_q <= 1'b1;
                    ext_q   <= 1'b0;
                    brk_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_FLUSH;
            endcase
        end
    end
endmodule
